// File: rtl/tmds_decoder.sv
// TMDS receive channel: finds symbol alignment from control-token runs in the raw deserializer
// stream, then decodes each aligned symbol to video data or control bits.
module tmds_decoder #(
   parameter int unsigned LOCK_COUNT = 8,
   parameter int unsigned TIMEOUT    = 2048
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] raw_in,
   output logic [7:0] data_out,
   output logic [1:0] ctrl_out,
   output logic       de_out,
   output logic       locked,
   output logic [3:0] offset
);

   localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLock  = CntW'(LOCK_COUNT);
   localparam logic [TmrW-1:0] TmrLimit = TmrW'(TIMEOUT);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);

   typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

   state_e          state_q, state_d;
   logic [9:0]      raw_prev_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic [3:0]      offset_q, offset_d;
   logic            locked_q, locked_d;
   logic            de_q, de_d;
   logic [7:0]      data_q, data_d;
   logic [1:0]      ctrl_q, ctrl_d;

   logic [19:0]     window;
   logic [9:0]      aligned;
   logic            hit_any;
   logic [3:0]      hit_idx;
   logic            aligned_tok;
   logic [1:0]      aligned_cd;

   function automatic logic is_token(input logic [9:0] s);
      return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
   endfunction

   function automatic logic [1:0] token_cd(input logic [9:0] s);
      logic [1:0] cd;
      case (s)
         10'h0AB: cd = 2'b01;
         10'h154: cd = 2'b10;
         10'h2AB: cd = 2'b11;
         default: cd = 2'b00;
      endcase
      return cd;
   endfunction

   // Undo the conditional inversion, then the XOR/XNOR transition chain.
   function automatic logic [7:0] tmds_data(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] d;
      q    = s[7:0] ^ {8{s[9]}};
      d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
      return d;
   endfunction

   assign window = {raw_in, raw_prev_q};

   // Scan downward so the lowest matching offset is the one left standing.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = 4'd0;
      for (int k = 9; k >= 0; k--) begin
         if (is_token(window[k +: 10])) begin
            hit_any = 1'b1;
            hit_idx = 4'(k);
         end
      end
   end

   always_comb begin
      aligned = window[9:0];
      for (int k = 0; k < 10; k++) begin
         if (offset_q == 4'(k)) begin
            aligned = window[k +: 10];
         end
      end
   end

   assign aligned_tok = is_token(aligned);
   assign aligned_cd  = token_cd(aligned);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      offset_d = offset_q;
      locked_d = locked_q;
      de_d     = 1'b0;
      data_d   = 8'd0;
      ctrl_d   = 2'b00;
      unique case (state_q)
         StSearch: begin
            if (hit_any) begin
               offset_d = hit_idx;
               cnt_d    = CntOne;
               state_d  = StVerify;
            end
         end
         StVerify: begin
            if (aligned_tok) begin
               cnt_d = cnt_q + CntOne;
               if (cnt_q + CntOne == CntLock) begin
                  state_d  = StLocked;
                  locked_d = 1'b1;
                  timer_d  = '0;
               end
            end else if (hit_any) begin
               offset_d = hit_idx;
               cnt_d    = CntOne;
            end else begin
               state_d = StSearch;
               cnt_d   = '0;
            end
         end
         StLocked: begin
            if (aligned_tok) begin
               timer_d = '0;
               ctrl_d  = aligned_cd;
            end else if (timer_q + 1'b1 == TmrLimit) begin
               state_d  = StSearch;
               locked_d = 1'b0;
               cnt_d    = '0;
               timer_d  = '0;
            end else begin
               timer_d = timer_q + 1'b1;
               de_d    = 1'b1;
               data_d  = tmds_data(aligned);
               ctrl_d  = ctrl_q;
            end
         end
         default: begin
            state_d = StSearch;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StSearch;
         raw_prev_q <= 10'd0;
         cnt_q      <= '0;
         timer_q    <= '0;
         offset_q   <= 4'd0;
         locked_q   <= 1'b0;
         de_q       <= 1'b0;
         data_q     <= 8'd0;
         ctrl_q     <= 2'b00;
      end else begin
         state_q    <= state_d;
         raw_prev_q <= raw_in;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         offset_q   <= offset_d;
         locked_q   <= locked_d;
         de_q       <= de_d;
         data_q     <= data_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign data_out = data_q;
   assign ctrl_out = ctrl_q;
   assign de_out   = de_q;
   assign locked   = locked_q;
   assign offset   = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: serial bit-stream stimulus, a behavioural alignment/decode model,
// a TMDS encoder feeding a byte scoreboard, and directed lock/timeout/reset sequences.
module tb_tmds_decoder;

   localparam int LockCount = 8;
   localparam int Timeout   = 2048;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] raw_in = 10'd0;
   logic [7:0] data_out;
   logic [1:0] ctrl_out;
   logic       de_out;
   logic       locked;
   logic [3:0] offset;

   tmds_decoder #(
      .LOCK_COUNT(LockCount),
      .TIMEOUT   (Timeout)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_in  (raw_in),
      .data_out(data_out),
      .ctrl_out(ctrl_out),
      .de_out  (de_out),
      .locked  (locked),
      .offset  (offset)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: a 20-bit window of the serial stream, scanned for tokens.
   logic [9:0] m_prev;
   int         m_off, m_run, m_idle;
   bit         m_locked, m_de;
   logic [7:0] m_data;
   logic [1:0] m_ctrl;

   function automatic int cd_of(input logic [9:0] s);
      case (s)
         10'h354: return 0;
         10'h0AB: return 1;
         10'h154: return 2;
         10'h2AB: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] ref_decode(input logic [9:0] s);
      logic [7:0] q, d;
      q = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ !s[8];
      return d;
   endfunction

   task automatic model_reset();
      m_prev = 0; m_off = 0; m_run = 0; m_idle = 0;
      m_locked = 0; m_de = 0; m_data = 0; m_ctrl = 0;
   endtask

   task automatic model_step(input logic [9:0] w);
      logic [19:0] win;
      logic [9:0]  al;
      int          hit, cd_al;
      win = {w, m_prev};
      hit = -1;
      for (int k = 0; k < 10; k++) if (hit < 0 && cd_of(10'(win >> k)) >= 0) hit = k;
      al    = 10'(win >> m_off);
      cd_al = cd_of(al);
      if (m_locked) begin
         if (cd_al >= 0) begin
            m_idle = 0; m_de = 0; m_data = 0; m_ctrl = cd_al[1:0];
         end else begin
            m_idle++;
            if (m_idle == Timeout) begin
               m_locked = 0; m_run = 0; m_idle = 0; m_de = 0; m_data = 0; m_ctrl = 0;
            end else begin
               m_de = 1; m_data = ref_decode(al);
            end
         end
      end else begin
         m_de = 0; m_data = 0; m_ctrl = 0;
         if (m_run > 0 && cd_al >= 0) begin
            m_run++;
            if (m_run == LockCount) begin
               m_locked = 1; m_idle = 0;
            end
         end else if (hit >= 0) begin
            m_off = hit; m_run = 1;
         end else begin
            m_run = 0;
         end
      end
      m_prev = w;
   endtask

   typedef struct {logic [7:0] data; logic [1:0] ctrl;} sb_t;
   sb_t sb[$];
   bit  sb_on = 0;

   task automatic cycle(input logic [9:0] w);
      sb_t e;
      raw_in = w;
      model_step(w);
      @(posedge clk);
      #1;
      check("m_locked", locked, m_locked);
      check("m_offset", offset, m_off);
      check("m_de", de_out, m_de);
      check("m_data", data_out, m_data);
      check("m_ctrl", ctrl_out, m_ctrl);
      if (sb_on && de_out === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_byte", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            check("sb_data", data_out, e.data);
            check("sb_ctrl", ctrl_out, e.ctrl);
         end
      end
   endtask

   // Serial bit stream; bit 0 of each word is the earliest bit.
   bit bq[$];
   int enc_cnt = 0;
   logic [9:0] toks[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   task automatic put_sym(input logic [9:0] s);
      for (int i = 0; i < 10; i++) bq.push_back(s[i]);
   endtask

   task automatic put_bits(input int n, input bit rnd);
      for (int i = 0; i < n; i++) bq.push_back(rnd ? bit'($urandom_range(0, 1)) : 1'b0);
   endtask

   task automatic flush();
      logic [9:0] w;
      while (bq.size() >= 10) begin
         for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
         cycle(w);
      end
   endtask

   task automatic send(input logic [9:0] s);
      put_sym(s);
      flush();
   endtask

   task automatic put_token(input int cd);
      enc_cnt = 0;
      put_sym(toks[cd]);
   endtask

   // Full transmitter encoder, including running-disparity inversion.
   task automatic put_byte(input logic [7:0] d);
      logic [8:0] qm;
      logic [9:0] s;
      int         n1, n1q, n0q;
      bit         use_xnor;
      n1 = $countones(d);
      use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !use_xnor;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (enc_cnt == 0 || n1q == n0q) begin
         s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         if (!qm[8]) enc_cnt += n0q - n1q; else enc_cnt += n1q - n0q;
      end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
         s = {1'b1, qm[8], ~qm[7:0]};
         enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
      end else begin
         s = {1'b0, qm[8], qm[7:0]};
         enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
      end
      put_sym(s);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      raw_in  = 10'd0;
      bq.delete();
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic wait_lock(input logic [9:0] tok);
      int n;
      n = 0;
      while (locked !== 1'b1 && n < 40) begin
         send(tok);
         n++;
      end
      check("lock_reached", locked, 1);
   endtask

   typedef struct {logic [9:0] sym; logic de; logic [7:0] data; logic [1:0] ctrl;} vec_t;
   vec_t vecs[10];

   initial begin
      int slip, cd, last_cd, sel, n;
      int slips[2];
      sb_t e;

      vecs[0] = '{10'h100, 1'b1, 8'h00, 2'd0};
      vecs[1] = '{10'h200, 1'b1, 8'hFF, 2'd0};
      vecs[2] = '{10'h0AB, 1'b0, 8'h00, 2'd1};
      vecs[3] = '{10'h1FF, 1'b1, 8'h01, 2'd1};
      vecs[4] = '{10'h154, 1'b0, 8'h00, 2'd2};
      vecs[5] = '{10'h101, 1'b1, 8'h03, 2'd2};
      vecs[6] = '{10'h2AB, 1'b0, 8'h00, 2'd3};
      vecs[7] = '{10'h0FF, 1'b1, 8'hFF, 2'd3};
      vecs[8] = '{10'h300, 1'b1, 8'h01, 2'd3};
      vecs[9] = '{10'h354, 1'b0, 8'h00, 2'd0};

      do_reset();
      check("rst_locked", locked, 0);
      check("rst_offset", offset, 0);
      check("rst_de", de_out, 0);
      check("rst_data", data_out, 0);
      check("rst_ctrl", ctrl_out, 0);

      // Lock at offset 0: the first word only fills the history register.
      for (int i = 1; i <= 9; i++) begin
         send(10'h354);
         check("lock0_locked", locked, (i == 9));
      end
      check("lock0_offset", offset, 0);
      check("lock0_de_at_lock", de_out, 0);
      send(10'h354);
      check("lock0_ctrl", ctrl_out, 0);
      check("lock0_de", de_out, 0);

      // Decode table; at offset 0 a word shows on the outputs one cycle later.
      for (int i = 0; i < 10; i++) begin
         send(vecs[i].sym);
         if (i > 0) begin
            check("vec_de", de_out, vecs[i-1].de);
            check("vec_data", data_out, vecs[i-1].data);
            check("vec_ctrl", ctrl_out, vecs[i-1].ctrl);
         end
      end
      send(10'h354);
      check("vec_de", de_out, vecs[9].de);
      check("vec_data", data_out, vecs[9].data);
      check("vec_ctrl", ctrl_out, vecs[9].ctrl);

      // Bit-slipped streams of 0x2AB.
      slips[0] = 3;
      slips[1] = 9;
      foreach (slips[s]) begin
         do_reset();
         put_bits(slips[s], 1'b0);
         wait_lock(10'h2AB);
         check("slip_offset", offset, slips[s]);
         send(10'h2AB);
         check("slip_ctrl", ctrl_out, 3);
         check("slip_de", de_out, 0);
      end

      // Broken run at offset 2.
      do_reset();
      put_bits(2, 1'b0);
      for (int i = 0; i < 5; i++) send(10'h354);
      check("broken_pre", locked, 0);
      send(10'h3FF);
      for (int i = 1; i <= 9; i++) begin
         send(10'h354);
         check("broken_locked", locked, (i == 9));
      end
      check("broken_offset", offset, 2);

      // Encoded byte sweep with random blanking and slip.
      do_reset();
      slip = $urandom_range(0, 9);
      put_bits(slip, 1'b0);
      cd = $urandom_range(0, 3);
      wait_lock(toks[cd]);
      send(toks[cd]);
      send(toks[cd]);
      last_cd = cd;
      sb_on = 1;
      for (int b = 0; b < 256; b++) begin
         n = $urandom_range(0, 2);
         for (int j = 0; j < n; j++) begin
            cd = $urandom_range(0, 3);
            put_token(cd);
            last_cd = cd;
            flush();
         end
         put_byte(8'(b));
         e.data = 8'(b);
         e.ctrl = 2'(last_cd);
         sb.push_back(e);
         flush();
      end
      for (int j = 0; j < 3; j++) begin
         put_token(0);
         flush();
      end
      check("sb_drained", sb.size(), 0);
      sb_on = 0;

      // Timeout boundary at offset 0.
      do_reset();
      wait_lock(10'h354);
      for (int i = 0; i < Timeout; i++) send(10'h100);
      check("to_2047_locked", locked, 1);
      send(10'h100);
      check("to_2048_locked", locked, 0);
      check("to_2048_de", de_out, 0);
      wait_lock(10'h354);
      for (int i = 0; i < 1000; i++) send(10'h100);
      send(10'h354);
      for (int i = 0; i < Timeout; i++) send(10'h100);
      check("to_restart_kept", locked, 1);
      send(10'h100);
      check("to_restart_drop", locked, 0);

      // Asynchronous reset in the middle of active video.
      wait_lock(10'h354);
      for (int i = 0; i < 4; i++) send(10'h200);
      check("ar_pre_de", de_out, 1);
      #2 reset_n = 1'b0;
      #1;
      check("ar_locked", locked, 0);
      check("ar_de", de_out, 0);
      check("ar_data", data_out, 0);
      check("ar_ctrl", ctrl_out, 0);
      check("ar_offset", offset, 0);
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         send(10'h354);
         check("ar_relock", locked, (i == 9));
      end

      // Randomised stream against the model.
      do_reset();
      put_bits($urandom_range(0, 9), 1'b1);
      for (int it = 0; it < 1200; it++) begin
         sel = $urandom_range(0, 9);
         if (sel < 4) begin
            cd = $urandom_range(0, 3);
            n  = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) begin
               put_token(cd);
               flush();
            end
         end else if (sel < 8) begin
            n = $urandom_range(1, 30);
            for (int j = 0; j < n; j++) begin
               put_byte(8'($urandom));
               flush();
            end
         end else if (sel == 8) begin
            put_sym(10'($urandom));
            flush();
         end else begin
            put_bits($urandom_range(1, 9), 1'b1);
            flush();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
